u8layer_seq: RTL and testbench
==============================

// Module: u8layer_seq
// PURPOSE
//  Layer sequencer for the u8 conv/dwconv address generator. Fetches per-layer parameter
//  descriptors from a word-wide descriptor memory and writes them through the adrgen's
//  pwe/padr/pdata port. It then pulses kick and waits for run to fall before moving on.
//  Runs a list of n_layers back-to-back with no CPU involvement between layers.
// PARAMETERS
//  Np     1   parallel output pixels in adrgen (start-position words per layer)
//  NPRM   23  core param words per layer (padr 0..22)
//  AW     16  descriptor memory word-address width
//  TKICK  15  max cycles from kick to run rising before err is raised
// PORTS
//  clk        in   1    clock
//  xrst       in   1    asynchronous active-low reset
//  start      in   1    pulse: begin list; ignored while busy
//  abort      in   1    pulse: stop after current memory beat; no further kick
//  desc_base  in   AW   word address of descriptor 0
//  n_layers   in   8    number of layers in list
//  mem_req    out  1    descriptor read request
//  mem_adr    out  AW   descriptor word address
//  mem_rdy    in   1    request accepted this cycle (req&&rdy)
//  mem_rvalid in   1    read data valid (any latency >=1, in order, 1 outstanding)
//  mem_rdata  in   32   read data
//  pwe        out  1    adrgen param write strobe
//  padr       out  8    adrgen param address
//  pdata      out  32   adrgen param data
//  kick       out  1    adrgen one-frame start pulse
//  run        in   1    adrgen running flag
//  busy       out  1    list in progress
//  done       out  1    one-cycle pulse: list finished or aborted
//  layer_idx  out  8    index of layer currently loading/running
//  err        out  1    sticky: run never rose within TKICK; cleared by start
// BEHAVIOUR
//  Reset: all outputs 0; state Idle. Reset mid-list returns to Idle and drops all requests.
//  Descriptor layout: NW = NPRM+Np words per layer. Layer k starts at desc_base + k*NW.
//   Word w<NPRM goes to padr=w. Word NPRM+i goes to padr=24+i ({y[26:16],x[10:0]}).
//   mem_adr is computed with AW-bit wrap-around, without a multiply: the running address
//   increments by 1 for every word fetched.
//  FSM: Idle -> Fetch -> WaitData -> Write -> (Fetch | Kick) -> WaitRise -> WaitFall -> Next.
//   Idle: on start, layer_idx<=0, err<=0. If n_layers==0, pulse done next cycle and stay
//     Idle (busy stays 0). Otherwise busy<=1 and go to Fetch.
//   Fetch: hold mem_req=1 and mem_adr stable until mem_rdy. Then go to WaitData.
//   WaitData: on mem_rvalid, register pdata<=mem_rdata and padr<=mapped(w), then go to Write.
//   Write: pwe=1 for exactly one cycle. w++. Go to Fetch if w<NW-1, else to Kick.
//   Kick: kick=1 for one cycle. This happens at least 1 cycle after the last pwe.
//   WaitRise: wait for run==1. If run has not risen after TKICK cycles, set err, pulse
//     done, go to Idle.
//   WaitFall: wait for run==0. This phase has no timeout because layer length is unbounded.
//   Next: layer_idx++. If layer_idx==n_layers-1, pulse done, busy<=0, go to Idle;
//     otherwise go to Fetch.
//  Parameter writes never overlap a running layer; pwe is 0 whenever run==1.
//  abort: honoured in Fetch/WaitData only after the outstanding read completes, since the
//   read data is discarded. In WaitRise/WaitFall, abort waits for run==0. Every abort path
//   ends with done and a return to Idle.
//  start while busy: ignored. Simultaneous start+abort in Idle: start wins.
//  n_layers and desc_base are sampled at start. Later changes have no effect on the list.
//  Latency per layer, memory latency L: NW*(L+2)+1 cycles before kick.
// STRUCTURE
//  Shared package (logic_types.svh): u8_t/u24_t/u32_t. Add AdrgenParamMap constants
//   (PADR_POS_BASE=24) and the seq_state_e enum.
//  One natural sub-module, u8seq_memrd: a single-outstanding read requester
//  (req/rdy/rvalid/data register). The FSM, counters and watchdog live in the top.
// TESTING
//  1: Np=1, n_layers=1, L=1 memory -> 24 pwe with padr 0..22,24 in order, data matching
//     memory; kick 1 cycle after last pwe; done 1 cycle after run falls.
//  2: n_layers=3, desc_base=0x100 -> reads 0x100..0x147 contiguous; layer_idx 0,1,2;
//     exactly 3 kicks; done once.
//  3: n_layers=0 -> done pulse 1 cycle after start; no mem_req, pwe or kick.
//  4: run model never rises -> err=1 and done exactly TKICK+1 cycles after kick; next start
//     clears err.
//  5: abort during WaitFall with run held 50 more cycles -> no further fetch; done when run
//     falls; busy=0.
//  6: random mem_rdy stall / latency 1..5; xrst asserted mid-Fetch -> outputs 0
//     immediately; clean restart on next start.

Source files
------------

// File: rtl/u8layer_seq_pkg.sv
// Shared types, adrgen param map and sequencer states
// for the u8 layer sequencer.
package u8layer_seq_pkg;

    typedef logic [7:0]  u8_t;
    typedef logic [23:0] u24_t;
    typedef logic [31:0] u32_t;

    // adrgen param map: core words at 0..NPRM-1,
    // start-position words from PADR_POS_BASE up
    localparam u8_t PADR_POS_BASE = 8'd24;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAITD,
        S_WRITE,
        S_KICK,
        S_WRISE,
        S_WFALL,
        S_NEXT
    } seq_state_e;

    function automatic u8_t map_padr(
        input u8_t w,
        input u8_t nprm
    );
        if (w < nprm)
            return w;
        return PADR_POS_BASE + (w - nprm);
    endfunction

endpackage

// File: rtl/u8layer_seq_memrd.sv
// Single-outstanding descriptor read requester.
// Ports: clk/xrst; i_go,i_adr from FSM; o_req,o_adr,i_rdy,
// i_rvalid,i_rdata to memory; o_acc,o_dv,o_data to FSM.
module u8layer_seq_memrd
    import u8layer_seq_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          xrst,
    input  logic          i_go,
    input  logic [AW-1:0] i_adr,
    output logic          o_req,
    output logic [AW-1:0] o_adr,
    input  logic          i_rdy,
    input  logic          i_rvalid,
    input  u32_t          i_rdata,
    output logic          o_acc,
    output logic          o_dv,
    output u32_t          o_data
);

    logic r_pend;
    u32_t r_data;

    // no new request while a read is in flight
    assign o_req  = i_go && !r_pend;
    assign o_adr  = i_adr;
    assign o_acc  = o_req && i_rdy;
    // stale rvalid after a reset is ignored
    assign o_dv   = i_rvalid && r_pend;
    assign o_data = r_data;

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_pend <= 1'b0;
            r_data <= '0;
        end else begin
            if (o_acc)
                r_pend <= 1'b1;
            else if (o_dv)
                r_pend <= 1'b0;
            if (o_dv)
                r_data <= i_rdata;
        end
    end

endmodule

// File: rtl/u8layer_seq.sv
// Layer sequencer: loads adrgen params per layer, kicks, waits.
// Ports: start/abort/desc_base/n_layers control; mem_* descriptor
// read; pwe/padr/pdata/kick/run adrgen; busy/done/layer_idx/err.
module u8layer_seq
    import u8layer_seq_pkg::*;
#(
    parameter int Np    = 1,
    parameter int NPRM  = 23,
    parameter int AW    = 16,
    parameter int TKICK = 15
) (
    input  logic          clk,
    input  logic          xrst,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] desc_base,
    input  logic [7:0]    n_layers,
    output logic          mem_req,
    output logic [AW-1:0] mem_adr,
    input  logic          mem_rdy,
    input  logic          mem_rvalid,
    input  logic [31:0]   mem_rdata,
    output logic          pwe,
    output logic [7:0]    padr,
    output logic [31:0]   pdata,
    output logic          kick,
    input  logic          run,
    output logic          busy,
    output logic          done,
    output logic [7:0]    layer_idx,
    output logic          err
);

    localparam int CW = $clog2(TKICK + 1);
    localparam u8_t NW = u8_t'(NPRM + Np);

    seq_state_e    r_state;
    seq_state_e    w_nxt;
    logic [AW-1:0] r_adr;
    u8_t           r_w;
    u8_t           r_layer;
    u8_t           r_nl;
    u8_t           r_padr;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic          r_abt;

    logic w_go;
    logic w_acc;
    logic w_dv;
    u32_t w_rdata;
    logic w_abt;
    logic w_last;
    logic w_ld;
    logic w_fin;
    logic w_tmo;

    assign w_go   = (r_state == S_FETCH);
    assign w_abt  = r_abt || abort;
    assign w_last = (r_layer == r_nl - 8'd1);

    u8layer_seq_memrd #(
        .AW (AW)
    ) u_memrd (
        .clk      (clk),
        .xrst     (xrst),
        .i_go     (w_go),
        .i_adr    (r_adr),
        .o_req    (mem_req),
        .o_adr    (mem_adr),
        .i_rdy    (mem_rdy),
        .i_rvalid (mem_rvalid),
        .i_rdata  (mem_rdata),
        .o_acc    (w_acc),
        .o_dv     (w_dv),
        .o_data   (w_rdata)
    );

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst)
            r_state <= S_IDLE;
        else
            r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        w_ld  = 1'b0;
        w_fin = 1'b0;
        w_tmo = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_ld = 1'b1;
                    if (n_layers == 8'd0)
                        w_fin = 1'b1;
                    else
                        w_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                // abort waits until the beat completes
                if (w_acc)
                    w_nxt = S_WAITD;
            end
            S_WAITD: begin
                if (w_dv) begin
                    if (w_abt) begin
                        w_fin = 1'b1;
                        w_nxt = S_IDLE;
                    end else begin
                        w_nxt = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (w_abt) begin
                    w_fin = 1'b1;
                    w_nxt = S_IDLE;
                end else if (r_w < NW - 8'd1) begin
                    w_nxt = S_FETCH;
                end else begin
                    w_nxt = S_KICK;
                end
            end
            S_KICK: begin
                if (w_abt) begin
                    w_fin = 1'b1;
                    w_nxt = S_IDLE;
                end else begin
                    w_nxt = S_WRISE;
                end
            end
            S_WRISE: begin
                // a kicked frame always completes, even on abort
                if (run) begin
                    w_nxt = S_WFALL;
                end else if (r_cnt == CW'(TKICK - 1)) begin
                    w_tmo = 1'b1;
                    w_fin = 1'b1;
                    w_nxt = S_IDLE;
                end
            end
            S_WFALL: begin
                if (!run) begin
                    if (w_abt || w_last) begin
                        w_fin = 1'b1;
                        w_nxt = S_IDLE;
                    end else begin
                        w_nxt = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                if (w_abt) begin
                    w_fin = 1'b1;
                    w_nxt = S_IDLE;
                end else begin
                    w_nxt = S_FETCH;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_adr   <= '0;
            r_w     <= '0;
            r_layer <= '0;
            r_nl    <= '0;
            r_padr  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_abt   <= 1'b0;
        end else begin
            r_done <= w_fin;
            if (w_ld) begin
                r_adr   <= desc_base;
                r_nl    <= n_layers;
                r_layer <= '0;
                r_err   <= 1'b0;
                r_busy  <= (n_layers != 8'd0);
            end
            if (w_acc)
                r_adr <= r_adr + 1'b1;
            if (w_dv)
                r_padr <= map_padr(r_w, u8_t'(NPRM));
            if (w_ld)
                r_w <= '0;
            else if (r_state == S_WRITE)
                r_w <= (r_w == NW - 8'd1) ? 8'd0 : r_w + 8'd1;
            if (r_state == S_NEXT && !w_abt)
                r_layer <= r_layer + 8'd1;
            r_cnt <= (r_state == S_WRISE) ? r_cnt + 1'b1 : '0;
            if (w_tmo)
                r_err <= 1'b1;
            if (w_ld || w_fin)
                r_abt <= 1'b0;
            else if (abort && r_state != S_IDLE)
                r_abt <= 1'b1;
            if (w_fin) begin
                r_busy <= 1'b0;
                r_w    <= '0;
            end
        end
    end

    assign pwe       = (r_state == S_WRITE);
    assign kick      = (r_state == S_KICK) && !w_abt;
    assign padr      = r_padr;
    assign pdata     = w_rdata;
    assign busy      = r_busy;
    assign done      = r_done;
    assign layer_idx = r_layer;
    assign err       = r_err;

endmodule

// File: tb/tb_u8layer_seq.sv
// Scoreboard bench for u8layer_seq: memory and adrgen run models,
// expected writes/addresses queued at start, popped on pwe/accept.
module tb_u8layer_seq;

    localparam int NW    = 24;
    localparam int NPRM  = 23;
    localparam int TKICK = 15;

    logic        clk;
    logic        xrst;
    logic        start;
    logic        abort;
    logic [15:0] desc_base;
    logic [7:0]  n_layers;
    logic        mem_req;
    logic [15:0] mem_adr;
    logic        mem_rdy;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        pwe;
    logic [7:0]  padr;
    logic [31:0] pdata;
    logic        kick;
    logic        run;
    logic        busy;
    logic        done;
    logic [7:0]  layer_idx;
    logic        err;

    u8layer_seq dut (
        .clk        (clk),
        .xrst       (xrst),
        .start      (start),
        .abort      (abort),
        .desc_base  (desc_base),
        .n_layers   (n_layers),
        .mem_req    (mem_req),
        .mem_adr    (mem_adr),
        .mem_rdy    (mem_rdy),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .pwe        (pwe),
        .padr       (padr),
        .pdata      (pdata),
        .kick       (kick),
        .run        (run),
        .busy       (busy),
        .done       (done),
        .layer_idx  (layer_idx),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int n_acc, n_pwe, n_kick, n_done;
    int start_cyc, kick_cyc, done_cyc, fall_cyc, last_pwe;
    bit busy_seen, err_at_done;
    bit stall = 0;
    bit rlat = 0;
    bit run_en = 1;
    int run_len = 5;

    logic [39:0] q_wr[$];
    logic [15:0] q_adr[$];

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] mdat(input logic [15:0] a);
        return {a ^ 16'hC35A, a + 16'h1234};
    endfunction

    initial forever @(posedge clk) cyc++;

    // descriptor memory: 1 outstanding, latency 1 or random 1..5
    initial begin : mem_model
        bit          acc;
        bit          pend;
        int          cnt;
        logic [15:0] a_acc;
        logic [15:0] a_p;
        pend = 0;
        cnt = 0;
        a_p = '0;
        mem_rdy = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            acc = mem_req && mem_rdy;
            a_acc = mem_adr;
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
            mem_rdata = $urandom;
            if (acc) begin
                pend = 1;
                cnt = rlat ? int'($urandom_range(1, 5)) : 1;
                a_p = a_acc;
            end
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = mdat(a_p);
                    pend = 0;
                end
            end
            if (!xrst) begin
                pend = 0;
                mem_rvalid = 1'b0;
            end
            mem_rdy = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // adrgen run flag model
    initial begin : run_model
        run = 1'b0;
        forever begin
            @(negedge clk);
            if (kick && run_en) begin
                @(posedge clk);
                #1 run = 1'b1;
                repeat (run_len) @(posedge clk);
                #1 run = 1'b0;
                fall_cyc = cyc;
            end
        end
    end

    initial begin : monitor
        logic [39:0] e;
        forever begin
            @(negedge clk);
            if (busy)
                busy_seen = 1;
            if (mem_req && mem_rdy) begin
                n_acc++;
                if (q_adr.size() == 0)
                    chk("adr_extra", 1, 0);
                else
                    chk("mem_adr", {16'h0, mem_adr}, {16'h0, q_adr.pop_front()});
            end
            if (pwe) begin
                n_pwe++;
                last_pwe = cyc;
                chk("pwe_run", {31'h0, run}, 0);
                if (q_wr.size() == 0) begin
                    chk("wr_extra", 1, 0);
                end else begin
                    e = q_wr.pop_front();
                    chk("padr", {24'h0, padr}, {24'h0, e[39:32]});
                    chk("pdata", pdata, e[31:0]);
                end
            end
            if (kick) begin
                chk("kick_gap", cyc - last_pwe, 1);
                chk("kick_idx", {24'h0, layer_idx}, n_kick);
                n_kick++;
                kick_cyc = cyc;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
                err_at_done = err;
            end
        end
    end

    task automatic clr();
        n_acc = 0;
        n_pwe = 0;
        n_kick = 0;
        n_done = 0;
        busy_seen = 0;
    endtask

    task automatic run_list(input logic [15:0] base,
                            input int n, input int n_exp);
        logic [15:0] a;
        logic [7:0]  pa;
        @(posedge clk);
        #1;
        for (int k = 0; k < n_exp; k++) begin
            for (int w = 0; w < NW; w++) begin
                a = base + 16'(k * NW + w);
                pa = (w < NPRM) ? 8'(w) : 8'(24 + w - NPRM);
                q_adr.push_back(a);
                q_wr.push_back({pa, mdat(a)});
            end
        end
        desc_base = base;
        n_layers = 8'(n);
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        desc_base = 16'hBEEF;
        n_layers = 8'hFF;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int t;
        t = 0;
        while (n_done == 0 && t < budget) begin
            @(posedge clk);
            t++;
        end
        repeat (4) @(posedge clk);
        chk(tag, n_done, 1);
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "_ctl"},
            {26'h0, mem_req, pwe, kick, busy, done, err}, 0);
        chk({tag, "_adr"}, {16'h0, mem_adr}, 0);
        chk({tag, "_pdat"}, pdata, 0);
        chk({tag, "_idx"}, {16'h0, layer_idx, padr}, 0);
    endtask

    task automatic sb_empty(input string tag);
        chk({tag, "_wrq"}, q_wr.size(), 0);
        chk({tag, "_adq"}, q_adr.size(), 0);
    endtask

    initial begin : main
        int t;
        xrst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        desc_base = '0;
        n_layers = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_chk("rst");
        @(posedge clk);
        #1 xrst = 1'b1;

        // 1: single layer, latency 1
        clr();
        run_list(16'h0040, 1, 1);
        wait_done("t1_done", 500);
        chk("t1_pwe", n_pwe, NW);
        chk("t1_kick", n_kick, 1);
        chk("t1_klat", kick_cyc - start_cyc, NW * 3 + 1);
        chk("t1_dfall", done_cyc - fall_cyc, 1);
        chk("t1_busy", {31'h0, busy}, 0);
        sb_empty("t1");

        // 2: three layers, start while busy ignored
        clr();
        run_list(16'h0100, 3, 3);
        repeat (30) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("t2_done", 1000);
        chk("t2_acc", n_acc, 3 * NW);
        chk("t2_kick", n_kick, 3);
        chk("t2_idx", {24'h0, layer_idx}, 2);
        sb_empty("t2");

        // 3: empty list
        clr();
        run_list(16'h0200, 0, 0);
        wait_done("t3_done", 20);
        chk("t3_dlat", done_cyc - start_cyc, 1);
        chk("t3_act", n_acc + n_pwe + n_kick, 0);
        chk("t3_busy", {31'h0, busy_seen}, 0);

        // 4: run never rises, then restart clears err
        clr();
        run_en = 0;
        run_list(16'h0300, 1, 1);
        wait_done("t4_done", 500);
        chk("t4_tmo", done_cyc - kick_cyc, TKICK + 1);
        chk("t4_errd", {31'h0, err_at_done}, 1);
        chk("t4_err", {31'h0, err}, 1);
        chk("t4_busy", {31'h0, busy}, 0);
        sb_empty("t4");
        run_en = 1;
        clr();
        run_list(16'h0400, 1, 1);
        @(negedge clk);
        chk("t4_eclr", {31'h0, err}, 0);
        wait_done("t4b_done", 500);
        sb_empty("t4b");

        // 5: abort in WaitFall with long run
        clr();
        run_len = 60;
        run_list(16'h0500, 2, 1);
        t = 0;
        while (!run && t < 300) begin
            @(posedge clk);
            t++;
        end
        chk("t5_rise", {31'h0, run}, 1);
        repeat (5) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        wait_done("t5_done", 300);
        chk("t5_dfall", done_cyc - fall_cyc, 1);
        chk("t5_acc", n_acc, NW);
        chk("t5_kick", n_kick, 1);
        chk("t5_busy", {31'h0, busy}, 0);
        sb_empty("t5");
        run_len = 5;

        // 6: stalls, random latency, address wrap
        clr();
        stall = 1;
        rlat = 1;
        run_list(16'hFFF0, 2, 2);
        wait_done("t6_done", 3000);
        chk("t6_kick", n_kick, 2);
        sb_empty("t6");

        // 6b: reset mid-Fetch, then clean restart
        clr();
        run_list(16'h0600, 1, 1);
        t = 0;
        while (n_acc < 3 && t < 500) begin
            @(posedge clk);
            t++;
        end
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!mem_req && t < 100);
        chk("t6_req", {31'h0, mem_req}, 1);
        #2 xrst = 1'b0;
        #1 rst_chk("t6_rst");
        q_wr.delete();
        q_adr.delete();
        repeat (2) @(posedge clk);
        #1 xrst = 1'b1;
        clr();
        run_list(16'h0700, 1, 1);
        wait_done("t6b_done", 3000);
        chk("t6b_pwe", n_pwe, NW);
        sb_empty("t6b");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
